// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch stage: issues in-order word fetches, buffers returned words and feeds the
// F/D register, honouring decode stalls and single-delay-slot redirects.
module pipe_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic        dvalid
);
    localparam int unsigned XW = 32;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XW-1:0] r_fifo_inst [DEPTH];
    logic [XW-1:0] r_fifo_pc4  [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_req;
    logic [XW-1:0] r_addr;
    logic [XW-1:0] r_fpc;
    logic [XW-1:0] r_target;
    logic          r_pending;
    logic          r_discard;
    logic [XW-1:0] r_inst;
    logic [XW-1:0] r_dpc4;
    logic          r_dvalid;

    logic          w_ack;
    logic          w_fifo_empty;
    logic          w_fd_load;
    logic          w_redir;
    logic          w_flush;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;
    logic          w_push_mem;
    logic          w_issue;
    logic          w_pend_eff;
    logic [CW-1:0] w_count_next;
    logic [XW-1:0] w_target;
    logic [XW-1:0] w_fpc_eff;
    logic [XW-1:0] w_tgt_eff;
    logic [XW-1:0] w_fpc_next;

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign inst      = r_inst;
    assign dpc4      = r_dpc4;
    assign dvalid    = r_dvalid;

    // Handshake, FIFO movement and redirect resolution for this cycle.
    always_comb begin
        w_ack        = r_req & imem_ack;
        w_fifo_empty = (r_count == '0);
        w_fd_load    = wpcir | ~r_dvalid;
        w_redir      = r_dvalid & wpcir & (pcsource != 2'b00);
        w_flush      = w_redir & ~w_fifo_empty;
        w_pop        = w_fd_load & ~w_fifo_empty;
        w_push       = w_ack & ~r_discard & ~w_flush;
        w_bypass     = w_push & w_fd_load & w_fifo_empty;
        w_push_mem   = w_push & ~w_bypass;

        w_target = jpc;
        case (pcsource)
            2'b01:   w_target = bpc;
            2'b10:   w_target = rpc;
            default: w_target = jpc;
        endcase

        if (w_flush) w_count_next = '0;
        else         w_count_next = r_count - CW'(w_pop) + CW'(w_push_mem);

        // One outstanding fetch at most, and only with a FIFO slot reserved for its word.
        w_issue = (~r_req | imem_ack) & (w_count_next < CW'(DEPTH));

        w_fpc_eff  = r_fpc;
        w_pend_eff = r_pending;
        w_tgt_eff  = r_target;
        if (w_redir) begin
            if (w_flush || r_req) begin
                // Delay slot is already in the FIFO head or in flight: fetch resumes at target.
                w_fpc_eff  = w_target;
                w_pend_eff = 1'b0;
            end else begin
                w_fpc_eff  = r_dpc4;
                w_pend_eff = 1'b1;
                w_tgt_eff  = w_target;
            end
        end
        w_fpc_next = w_pend_eff ? w_tgt_eff : (w_fpc_eff + 32'd4);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_req     <= 1'b0;
            r_addr    <= RESET_PC;
            r_fpc     <= RESET_PC;
            r_target  <= '0;
            r_pending <= 1'b0;
            r_discard <= 1'b0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_inst    <= '0;
            r_dpc4    <= '0;
            r_dvalid  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req     <= 1'b1;
                r_addr    <= w_fpc_eff;
                r_fpc     <= w_fpc_next;
                r_pending <= 1'b0;
            end else begin
                r_req     <= r_req & ~imem_ack;
                r_fpc     <= w_fpc_eff;
                r_pending <= w_pend_eff;
            end
            r_target <= w_tgt_eff;

            if (w_ack)                r_discard <= 1'b0;
            else if (w_flush && r_req) r_discard <= 1'b1;

            r_count <= w_count_next;
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
                if (w_push_mem) r_wr_ptr <= r_wr_ptr + PW'(1);
            end

            if (w_fd_load) begin
                if (w_pop) begin
                    r_inst   <= r_fifo_inst[r_rd_ptr];
                    r_dpc4   <= r_fifo_pc4[r_rd_ptr];
                    r_dvalid <= 1'b1;
                end else if (w_bypass) begin
                    r_inst   <= imem_rdata;
                    r_dpc4   <= r_addr + 32'd4;
                    r_dvalid <= 1'b1;
                end else begin
                    r_dvalid <= 1'b0;
                end
            end
        end
    end

    // Word storage needs no reset: occupancy is tracked by r_count.
    always_ff @(posedge clock) begin
        if (w_push_mem) begin
            r_fifo_inst[r_wr_ptr] <= imem_rdata;
            r_fifo_pc4[r_wr_ptr]  <= r_addr + 32'd4;
        end
    end
endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Randomised bench for pipe_fetch_unit: a program-order address model feeds a scoreboard that
// checks every instruction decode consumes, against a random-latency instruction memory.
module tb_pipe_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } dchk_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wpcir = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0, rpc = '0, jpc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst, dpc4;
    logic        dvalid;

    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stray_ack = 1'b0;
    logic        stray_pend = 1'b0;
    logic        stray_chk = 1'b0;
    int          lat_max = 0;

    logic [31:0] q_exp[$];
    logic [31:0] q_served[$];
    dchk_t       q_dir[$];

    int          n_checks = 0;
    int          n_pass = 0;

    logic [31:0] m_last;
    logic [31:0] m_tgt;
    bit          m_pend;

    assign imem_ack   = mem_ack | stray_ack;
    assign imem_rdata = stray_ack ? 32'hBAD0_BAD0 : mem_rdata;

    pipe_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clock(clock), .resetn(resetn), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .dpc4(dpc4), .dvalid(dvalid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
        return 32'($urandom_range(0, 2047)) << 2;
    endfunction

    // Instruction memory: acks each request after a random 0..lat_max cycles.
    bit busy = 1'b0;
    int cur_lat = 0;
    int cnt = 0;
    always @(posedge clock) begin
        #1;
        if (!resetn || !imem_req) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
        end else begin
            if (!busy) begin
                busy    = 1'b1;
                cur_lat = int'($urandom_range(0, lat_max));
                cnt     = 0;
            end
            if (cnt >= cur_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = word_at(imem_addr);
                q_served.push_back(imem_addr);
                busy      = 1'b0;
            end else begin
                mem_ack = 1'b0;
                cnt++;
            end
        end
    end

    task automatic tally(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Scoreboard monitor: every instruction consumed by decode is compared with the model.
    int          idle = 0;
    dchk_t       d;
    logic [31:0] e;
    always @(negedge clock) begin
        while (q_dir.size() > 0) begin
            d = q_dir.pop_front();
            tally(d.name, d.got, d.exp);
        end
        if (!resetn) begin
            idle = 0;
        end else begin
            if (stray_chk) tally("stray_ack_dvalid", 32'(dvalid), 32'd0);
            if (dvalid && wpcir) begin
                idle = 0;
                if (q_exp.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_delivery: got dpc4 %h expected no instruction", dpc4);
                end else begin
                    e = q_exp.pop_front();
                    tally("dpc4", dpc4, e + 32'd4);
                    tally("inst", inst, word_at(e));
                end
            end else begin
                idle++;
                if (idle > 64) begin
                    n_checks++;
                    $display("FAIL watchdog: got %0d idle cycles expected at most 64", idle);
                    idle = 0;
                end
            end
        end
    end

    task automatic model_reset();
        q_exp.delete();
        m_last = RST_PC;
        m_pend = 1'b0;
        q_exp.push_back(RST_PC);
    endtask

    // Decode-side driver; the model pushes the next program-order address on each consumption.
    task automatic run(input int n, input int stall_pct, input int redir_pct, input bit do_reset);
        bit          wp;
        int          sel;
        bit          found;
        found = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            #1;
            stray_ack  = 1'b0;
            stray_chk  = stray_pend;
            stray_pend = 1'b0;
            wp       = ($urandom_range(0, 99) >= stall_pct);
            bpc      = rand_target();
            rpc      = rand_target();
            jpc      = rand_target();
            pcsource = 2'($urandom_range(0, 3));
            if (dvalid && wp) begin
                if (!m_pend && $urandom_range(0, 99) < redir_pct) begin
                    sel      = int'($urandom_range(1, 3));
                    pcsource = 2'(sel);
                    m_tgt    = (sel == 1) ? bpc : (sel == 2) ? rpc : jpc;
                    m_pend   = 1'b1;
                    m_last   = m_last + 32'd4;
                end else if (m_pend) begin
                    pcsource = 2'b00;
                    m_last   = m_tgt;
                    m_pend   = 1'b0;
                end else begin
                    pcsource = 2'b00;
                    m_last   = m_last + 32'd4;
                end
                q_exp.push_back(m_last);
            end
            wpcir = wp;
            if (do_reset) begin
                #2;
                if (imem_req && !imem_ack) begin
                    resetn = 1'b0;
                    #1;
                    q_dir.push_back('{"rst_imem_req", 32'(imem_req), 32'd0});
                    q_dir.push_back('{"rst_imem_addr", imem_addr, RST_PC});
                    q_dir.push_back('{"rst_dvalid", 32'(dvalid), 32'd0});
                    q_dir.push_back('{"rst_inst", inst, 32'd0});
                    q_dir.push_back('{"rst_dpc4", dpc4, 32'd0});
                    found = 1'b1;
                    break;
                end
            end
        end
        if (do_reset) q_dir.push_back('{"reset_window_found", 32'(found), 32'd1});
    endtask

    task automatic release_reset(input bit with_stray);
        @(negedge clock);
        #1;
        wpcir      = 1'b1;
        pcsource   = 2'b00;
        stray_ack  = with_stray;
        stray_pend = with_stray;
        resetn     = 1'b1;
    endtask

    initial begin
        #2;
        q_dir.push_back('{"init_imem_req", 32'(imem_req), 32'd0});
        q_dir.push_back('{"init_imem_addr", imem_addr, RST_PC});
        q_dir.push_back('{"init_dvalid", 32'(dvalid), 32'd0});
        q_dir.push_back('{"init_inst", inst, 32'd0});
        q_dir.push_back('{"init_dpc4", dpc4, 32'd0});
        repeat (2) @(negedge clock);
        model_reset();
        lat_max = 0;
        release_reset(1'b0);

        run(12, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (q_served.size() > i)
                q_dir.push_back('{$sformatf("first_addr%0d", i), q_served[i], RST_PC + 32'(4 * i)});
            else
                q_dir.push_back('{"first_addr_count", 32'(q_served.size()), 32'd3});
        end

        run(200, 35, 0, 1'b0);
        run(400, 25, 20, 1'b0);
        lat_max = 3;
        run(400, 20, 20, 1'b0);
        lat_max = 1;
        run(300, 40, 30, 1'b0);

        lat_max = 3;
        run(200, 10, 10, 1'b1);
        #1;
        model_reset();
        repeat (2) @(negedge clock);
        lat_max = 0;
        release_reset(1'b1);
        run(50, 0, 0, 1'b0);
        lat_max = 2;
        run(300, 20, 20, 1'b0);

        wpcir    = 1'b0;
        pcsource = 2'b00;
        repeat (3) @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
